dcache_req_responder: RTL and testbench
=======================================

# dcache_req_responder

Memory-side responder for the load/store request interface driven by the MEM1 stage (ce/we/addr/pc/sel/data/rd_type/wr_type, answered by a busy level). It accepts one request at a time and runs a single blocking read or write transaction on a simple valid/ready memory bus. It raises busy while the request is outstanding and returns the raw 32-bit load word to MEM2 with a one-cycle valid pulse. Pipeline flushes during a transaction suppress the response but never abort the bus transaction.

## Interface

Parameters:
- ADDR_W, 32, request/bus address width
- DATA_W, 32, data width; fixed at 32, byte strobes are DATA_W/8

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  pipeline flush; kills the response of any in-flight request
- req_ce  in  1  request valid (chip enable)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  physical byte address
- req_pc  in  32  pc of the requesting instruction; debug only
- req_sel  in  4  byte-lane select
- req_data  in  DATA_W  store data, already lane-replicated
- req_rd_type  in  3  load size: 000 byte, 001 half, 010 word
- req_wr_type  in  3  store size, same encoding
- busy_o  out  1  request outstanding; drives the initiator's cache_ack
- resp_valid_o  out  1  one-cycle response pulse
- resp_data_o  out  DATA_W  raw load word; 0 for stores
- resp_pc_o  out  32  pc of the responding request
- bus_rd_req  out  1  read request valid
- bus_rd_addr  out  ADDR_W  read address
- bus_rd_type  out  3  read size
- bus_rd_ready  in  1  read request accepted
- bus_ret_valid  in  1  read data valid
- bus_ret_data  in  DATA_W  read data
- bus_wr_req  out  1  write request valid
- bus_wr_addr  out  ADDR_W  write address
- bus_wr_type  out  3  write size
- bus_wr_strb  out  4  byte strobes (= latched sel)
- bus_wr_data  out  DATA_W  write data
- bus_wr_ready  in  1  write request accepted
- bus_wr_done  in  1  write completion

## Operation

- FSM states:
  - IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- Accept:
  - A request is accepted in IDLE or RESP when req_ce=1 and flush=0.
  - On accept, latch addr, pc, sel, data, rd_type and wr_type, clear kill, then go to WR_REQ (req_we=1) or RD_REQ (req_we=0).
  - req_ce in any other state is ignored; the initiator must not assert ce while busy_o=1.
- RD_REQ:
  - bus_rd_req=1 with the latched addr and type.
  - bus_rd_ready=1 moves to RD_WAIT.
- RD_WAIT:
  - bus_ret_valid=1 captures bus_ret_data into the response register and moves to RESP.
  - bus_ret_valid is ignored in every other state.
- WR_REQ:
  - bus_wr_req=1 with the latched addr, type, strb and data.
  - bus_wr_ready=1 moves to WR_WAIT.
- WR_WAIT:
  - bus_wr_done=1 sets the response data to 0 and moves to RESP.
- RESP:
  - resp_valid_o = !kill.
  - Next state is IDLE, or a new RD_REQ/WR_REQ if a request is accepted in the same cycle.
- Flush:
  - flush=1 in RD_REQ, RD_WAIT, WR_REQ or WR_WAIT sets kill.
  - The bus transaction still completes; stores reach memory. RESP then emits no pulse.
  - flush in the RESP cycle masks that cycle's pulse.
- busy_o = 1 in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT; 0 in IDLE and RESP.
- bus_*_req outputs are registered-state decodes: stable and held until ready.
- Reset:
  - State is IDLE; every output and every latched field is 0.
  - Reset asserted mid-transaction abandons it immediately; the bus side is not waited on.

## Timing

- Load accepted at cycle 0 with ready and return both immediate:
  - busy_o and bus_rd_req are 1 at cycle 1.
  - RD_WAIT at cycle 2; ret_valid at cycle 2.
  - resp_valid_o=1 at cycle 3. Minimum load latency is 3 cycles.
- Store minimum latency is also 3 cycles; each extra cycle of ready or done delay adds one.
- Back-to-back:
  - A new request may be accepted in the RESP cycle.
  - No idle bubble is required between transactions.
- busy_o falls in the same cycle as resp_valid_o rises.
- Response outputs are registered. resp_data_o/resp_pc_o hold their last value when resp_valid_o=0.

## Test plan

- Load word at 0x1C000100, ready at cycle 1, ret_valid at cycle 4 with data 0xDEADBEEF:
  - Required: bus_rd_req at cycles 1; resp_valid_o=1 at cycle 5 with data 0xDEADBEEF; busy_o=1 at cycles 1-4.
- Store byte at addr 0x3 with sel=1000 and data 0x5A5A5A5A:
  - Required: bus_wr_strb=1000 and bus_wr_type=000, held until bus_wr_ready.
  - After bus_wr_done: resp_valid_o with data 0.
- Flush during RD_WAIT:
  - Required: the read still completes on the bus, no resp_valid_o, state returns to IDLE.
  - A following load at addr 0x40 returns normally.
- Back-to-back: a second load asserted in the RESP cycle of the first:
  - Required: accepted immediately; bus_rd_req is 1 in the next cycle with the new address.
- req_ce=1 with flush=1 in IDLE:
  - Required: not accepted, busy_o stays 0.
- Stray ret_valid in IDLE is ignored.
- rst_n asserted in WR_WAIT:
  - Required: all outputs 0 asynchronously, FSM in IDLE.
  - A later bus_wr_done produces no response.

Source files
------------

// File: rtl/dcache_req_responder.sv
// Memory-side responder for MEM1 load/store requests: runs one blocking read or
// write on a valid/ready bus per request and returns a one-cycle response to MEM2.
module dcache_req_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                req_ce,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_pc,
  input  logic [DATA_W/8-1:0] req_sel,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [2:0]          req_rd_type,
  input  logic [2:0]          req_wr_type,
  output logic                busy_o,
  output logic                resp_valid_o,
  output logic [DATA_W-1:0]   resp_data_o,
  output logic [31:0]         resp_pc_o,
  output logic                bus_rd_req,
  output logic [ADDR_W-1:0]   bus_rd_addr,
  output logic [2:0]          bus_rd_type,
  input  logic                bus_rd_ready,
  input  logic                bus_ret_valid,
  input  logic [DATA_W-1:0]   bus_ret_data,
  output logic                bus_wr_req,
  output logic [ADDR_W-1:0]   bus_wr_addr,
  output logic [2:0]          bus_wr_type,
  output logic [DATA_W/8-1:0] bus_wr_strb,
  output logic [DATA_W-1:0]   bus_wr_data,
  input  logic                bus_wr_ready,
  input  logic                bus_wr_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         pc_q;
  logic [DATA_W/8-1:0] sel_q;
  logic [DATA_W-1:0]   data_q;
  logic [2:0]          rd_type_q;
  logic [2:0]          wr_type_q;
  logic                kill_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [31:0]         resp_pc_q;

  logic accept;
  logic busy;

  assign busy   = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                  (state_q == WR_REQ) || (state_q == WR_WAIT);
  assign accept = req_ce && !flush && ((state_q == IDLE) || (state_q == RESP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pc_q        <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      rd_type_q   <= '0;
      wr_type_q   <= '0;
      kill_q      <= 1'b0;
      resp_data_q <= '0;
      resp_pc_q   <= '0;
    end else begin
      if (accept) begin
        addr_q    <= req_addr;
        pc_q      <= req_pc;
        sel_q     <= req_sel;
        data_q    <= req_data;
        rd_type_q <= req_rd_type;
        wr_type_q <= req_wr_type;
        kill_q    <= 1'b0;
        state_q   <= req_we ? WR_REQ : RD_REQ;
      end else begin
        case (state_q)
          RD_REQ:  if (bus_rd_ready) state_q <= RD_WAIT;
          RD_WAIT: if (bus_ret_valid) begin
            resp_data_q <= bus_ret_data;
            resp_pc_q   <= pc_q;
            state_q     <= RESP;
          end
          WR_REQ:  if (bus_wr_ready) state_q <= WR_WAIT;
          WR_WAIT: if (bus_wr_done) begin
            resp_data_q <= '0;
            resp_pc_q   <= pc_q;
            state_q     <= RESP;
          end
          RESP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
      // A flush never aborts the bus side; it only silences the eventual response.
      if (flush && busy) kill_q <= 1'b1;
    end
  end

  assign busy_o       = busy;
  assign resp_valid_o = (state_q == RESP) && !kill_q && !flush;
  assign resp_data_o  = resp_data_q;
  assign resp_pc_o    = resp_pc_q;

  assign bus_rd_req   = (state_q == RD_REQ);
  assign bus_rd_addr  = addr_q;
  assign bus_rd_type  = rd_type_q;

  assign bus_wr_req   = (state_q == WR_REQ);
  assign bus_wr_addr  = addr_q;
  assign bus_wr_type  = wr_type_q;
  assign bus_wr_strb  = sel_q;
  assign bus_wr_data  = data_q;

endmodule

// File: tb/tb_dcache_req_responder.sv
// Directed bench for dcache_req_responder: cycle checks plus a response scoreboard.
module tb_dcache_req_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_ce, req_we;
  logic [31:0] req_addr, req_pc, req_data;
  logic [3:0]  req_sel;
  logic [2:0]  req_rd_type, req_wr_type;
  logic        busy_o, resp_valid_o;
  logic [31:0] resp_data_o, resp_pc_o;
  logic        bus_rd_req;
  logic [31:0] bus_rd_addr;
  logic [2:0]  bus_rd_type;
  logic        bus_rd_ready, bus_ret_valid;
  logic [31:0] bus_ret_data;
  logic        bus_wr_req;
  logic [31:0] bus_wr_addr, bus_wr_data;
  logic [2:0]  bus_wr_type;
  logic [3:0]  bus_wr_strb;
  logic        bus_wr_ready, bus_wr_done;

  dcache_req_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr), .req_pc(req_pc),
    .req_sel(req_sel), .req_data(req_data), .req_rd_type(req_rd_type),
    .req_wr_type(req_wr_type),
    .busy_o(busy_o), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .resp_pc_o(resp_pc_o),
    .bus_rd_req(bus_rd_req), .bus_rd_addr(bus_rd_addr), .bus_rd_type(bus_rd_type),
    .bus_rd_ready(bus_rd_ready), .bus_ret_valid(bus_ret_valid),
    .bus_ret_data(bus_ret_data),
    .bus_wr_req(bus_wr_req), .bus_wr_addr(bus_wr_addr), .bus_wr_type(bus_wr_type),
    .bus_wr_strb(bus_wr_strb), .bus_wr_data(bus_wr_data),
    .bus_wr_ready(bus_wr_ready), .bus_wr_done(bus_wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   resp_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] p,
                       input logic [3:0] s, input logic [31:0] d, input logic [2:0] t);
    req_ce = 1'b1; req_we = we; req_addr = a; req_pc = p; req_sel = s; req_data = d;
    req_rd_type = t; req_wr_type = t;
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid_o) begin
      resp_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_resp_data", resp_data_o, e.data);
        check("sb_resp_pc", resp_pc_o, e.pc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_ce = 1'b0; req_we = 1'b0;
    req_addr = '0; req_pc = '0; req_sel = '0; req_data = '0;
    req_rd_type = '0; req_wr_type = '0;
    bus_rd_ready = 1'b0; bus_ret_valid = 1'b0; bus_ret_data = '0;
    bus_wr_ready = 1'b0; bus_wr_done = 1'b0;

    tick(); tick();
    settle();
    check("rst_busy", busy_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_rd_req", bus_rd_req, 0);
    check("rst_wr_req", bus_wr_req, 0);
    check("rst_resp_data", resp_data_o, 0);
    check("rst_rd_addr", bus_rd_addr, 0);
    rst_n = 1'b1;

    // Load word: ready at cycle 1, return at cycle 4
    tick();
    issue(1'b0, 32'h1C00_0100, 32'h8000_0000, 4'hF, 32'h0, 3'b010);
    push(32'hDEAD_BEEF, 32'h8000_0000);
    tick(); req_ce = 1'b0; settle();
    check("ld_c1_busy", busy_o, 1);
    check("ld_c1_rd_req", bus_rd_req, 1);
    check("ld_c1_rd_addr", bus_rd_addr, 32'h1C00_0100);
    check("ld_c1_rd_type", bus_rd_type, 3'b010);
    bus_rd_ready = 1'b1;
    tick(); bus_rd_ready = 1'b0; settle();
    check("ld_c2_rd_req", bus_rd_req, 0);
    check("ld_c2_busy", busy_o, 1);
    tick(); settle();
    check("ld_c3_busy", busy_o, 1);
    tick(); bus_ret_valid = 1'b1; bus_ret_data = 32'hDEAD_BEEF; settle();
    check("ld_c4_busy", busy_o, 1);
    check("ld_c4_no_resp", resp_valid_o, 0);
    tick(); bus_ret_valid = 1'b0; settle();
    check("ld_c5_resp_valid", resp_valid_o, 1);
    check("ld_c5_busy", busy_o, 0);
    check("ld_c5_resp_data", resp_data_o, 32'hDEAD_BEEF);
    tick(); settle();
    check("ld_c6_resp_valid", resp_valid_o, 0);
    check("ld_c6_data_hold", resp_data_o, 32'hDEAD_BEEF);

    // Store byte with delayed ready
    issue(1'b1, 32'h0000_0003, 32'h8000_0010, 4'b1000, 32'h5A5A_5A5A, 3'b000);
    push(32'h0, 32'h8000_0010);
    tick(); req_ce = 1'b0; settle();
    check("st_c1_wr_req", bus_wr_req, 1);
    check("st_c1_strb", bus_wr_strb, 4'b1000);
    check("st_c1_type", bus_wr_type, 3'b000);
    check("st_c1_addr", bus_wr_addr, 32'h3);
    check("st_c1_data", bus_wr_data, 32'h5A5A_5A5A);
    check("st_c1_rd_req", bus_rd_req, 0);
    tick(); settle();
    check("st_c2_wr_req_held", bus_wr_req, 1);
    check("st_c2_strb_held", bus_wr_strb, 4'b1000);
    bus_wr_ready = 1'b1;
    tick(); bus_wr_ready = 1'b0; settle();
    check("st_c3_wr_req", bus_wr_req, 0);
    check("st_c3_busy", busy_o, 1);
    bus_wr_done = 1'b1;
    tick(); bus_wr_done = 1'b0; settle();
    check("st_c4_resp_valid", resp_valid_o, 1);
    check("st_c4_resp_data", resp_data_o, 0);
    check("st_c4_busy", busy_o, 0);
    tick();

    // Flush during RD_WAIT: bus completes, no response
    issue(1'b0, 32'h0000_0080, 32'h8000_0020, 4'hF, 32'h0, 3'b010);
    tick(); req_ce = 1'b0; bus_rd_ready = 1'b1;
    tick(); bus_rd_ready = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; bus_ret_valid = 1'b1; bus_ret_data = 32'h1111_2222; settle();
    check("fl_busy_still", busy_o, 1);
    tick(); bus_ret_valid = 1'b0; settle();
    check("fl_no_resp", resp_valid_o, 0);
    check("fl_busy_clear", busy_o, 0);
    tick(); settle();
    check("fl_idle_busy", busy_o, 0);
    check("fl_idle_rd_req", bus_rd_req, 0);

    // Load at 0x40, then back-to-back load at 0x44 in its RESP cycle
    issue(1'b0, 32'h0000_0040, 32'h8000_0030, 4'hF, 32'h0, 3'b010);
    push(32'hCAFE_F00D, 32'h8000_0030);
    tick(); req_ce = 1'b0; bus_rd_ready = 1'b1;
    tick(); bus_rd_ready = 1'b0; bus_ret_valid = 1'b1; bus_ret_data = 32'hCAFE_F00D;
    tick(); bus_ret_valid = 1'b0; settle();
    check("b2b_first_resp", resp_valid_o, 1);
    issue(1'b0, 32'h0000_0044, 32'h8000_0034, 4'hF, 32'h0, 3'b001);
    push(32'h0BAD_C0DE, 32'h8000_0034);
    tick(); req_ce = 1'b0; settle();
    check("b2b_rd_req", bus_rd_req, 1);
    check("b2b_rd_addr", bus_rd_addr, 32'h44);
    check("b2b_rd_type", bus_rd_type, 3'b001);
    check("b2b_busy", busy_o, 1);
    bus_rd_ready = 1'b1;
    tick(); bus_rd_ready = 1'b0; bus_ret_valid = 1'b1; bus_ret_data = 32'h0BAD_C0DE;
    tick(); bus_ret_valid = 1'b0; settle();
    check("b2b_second_resp", resp_valid_o, 1);

    // Flush in the RESP cycle masks the pulse
    tick();
    issue(1'b0, 32'h0000_0050, 32'h8000_0040, 4'hF, 32'h0, 3'b010);
    tick(); req_ce = 1'b0; bus_rd_ready = 1'b1;
    tick(); bus_rd_ready = 1'b0; bus_ret_valid = 1'b1; bus_ret_data = 32'h0BAD_C0DE;
    tick(); bus_ret_valid = 1'b0; flush = 1'b1; settle();
    check("resp_flush_mask", resp_valid_o, 0);
    tick(); flush = 1'b0;

    // ce with flush in IDLE is not accepted
    issue(1'b0, 32'h0000_0060, 32'h8000_0050, 4'hF, 32'h0, 3'b010);
    flush = 1'b1;
    tick(); req_ce = 1'b0; flush = 1'b0; settle();
    check("ce_flush_busy", busy_o, 0);
    check("ce_flush_rd_req", bus_rd_req, 0);

    // Stray ret_valid in IDLE is ignored
    bus_ret_valid = 1'b1; bus_ret_data = 32'h7777_7777;
    tick(); bus_ret_valid = 1'b0; settle();
    check("stray_resp", resp_valid_o, 0);
    check("stray_busy", busy_o, 0);
    tick(); settle();
    check("stray_data_hold", resp_data_o, 32'h0BAD_C0DE);

    // Reset in WR_WAIT abandons the store
    issue(1'b1, 32'h0000_0100, 32'h8000_0060, 4'hF, 32'h1234_5678, 3'b010);
    tick(); req_ce = 1'b0; bus_wr_ready = 1'b1;
    tick(); bus_wr_ready = 1'b0; settle();
    check("rw_busy_before", busy_o, 1);
    rst_n = 1'b0; settle();
    check("rw_busy", busy_o, 0);
    check("rw_wr_req", bus_wr_req, 0);
    check("rw_wr_addr", bus_wr_addr, 0);
    check("rw_wr_data", bus_wr_data, 0);
    check("rw_resp_data", resp_data_o, 0);
    check("rw_resp_pc", resp_pc_o, 0);
    tick(); rst_n = 1'b1; bus_wr_done = 1'b1;
    tick(); bus_wr_done = 1'b0; settle();
    check("rw_done_no_resp", resp_valid_o, 0);
    check("rw_done_busy", busy_o, 0);
    tick(); tick();

    check("sb_empty", sb_q.size(), 0);
    check("resp_count", resp_seen, 4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
